// File: rtl/neuron_sum_sequencer.sv
// Walks the input groups of each neuron through the 8-input sign-magnitude adder tree,
// accumulates per-group results, and hands finished sums downstream over valid/ready.
// Build option: define NEURON_SUM_RELU_EN to clamp negative finished sums to zero.
module neuron_sum_sequencer #(
  parameter int GRP_W  = 4,
  parameter int NEU_W  = 6,
  parameter int ADDR_W = GRP_W + NEU_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GRP_W-1:0]  num_groups,
  input  logic [NEU_W-1:0]  num_neurons,
  output logic [ADDR_W-1:0] grp_addr,
  output logic              grp_rd,
  input  logic [14:0]       bias_in,
  output logic [14:0]       bias_out,
  output logic [NEU_W-1:0]  neuron_idx,
  input  logic [20:0]       tree_q,
  output logic [20:0]       sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ACC,
    S_OUT,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [GRP_W-1:0]  ngrp_q, ngrp_d;
  logic [GRP_W-1:0]  grp_idx_q, grp_idx_d;
  logic [NEU_W-1:0]  nneu_q, nneu_d;
  logic [NEU_W-1:0]  neu_idx_q, neu_idx_d;
  logic [20:0]       acc_q, acc_d;
  logic [20:0]       sum_q, sum_d;
  logic              valid_q, valid_d;

  logic              last_grp;
  logic              last_neu;
  logic              xfer;
  logic [20:0]       acc_sum;
  logic [20:0]       sum_load;

  // Sign-magnitude add with magnitude saturation; a zero result is always positive.
  function automatic logic [20:0] sm_add(input logic [20:0] a, input logic [20:0] b);
    logic [20:0] mag_sum;
    logic [19:0] mag;
    logic        sgn;
    mag_sum = {1'b0, a[19:0]} + {1'b0, b[19:0]};
    if (a[20] == b[20]) begin
      mag = mag_sum[20] ? '1 : mag_sum[19:0];
      sgn = a[20];
    end else if (a[19:0] >= b[19:0]) begin
      mag = a[19:0] - b[19:0];
      sgn = a[20];
    end else begin
      mag = b[19:0] - a[19:0];
      sgn = b[20];
    end
    return {sgn && (mag != '0), mag};
  endfunction

  assign last_grp = (grp_idx_q == ngrp_q - GRP_W'(1));
  assign last_neu = (neu_idx_q == nneu_q - NEU_W'(1));
  assign xfer     = (state_q == S_OUT) && valid_q && sum_ready;
  assign acc_sum  = sm_add(acc_q, tree_q);

`ifdef NEURON_SUM_RELU_EN
  assign sum_load = acc_sum[20] ? '0 : acc_sum;
`else
  assign sum_load = acc_sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (num_neurons == '0) ? S_FIN : S_FETCH;
      S_FETCH: state_d = S_ACC;
      S_ACC:   state_d = last_grp ? S_OUT : S_FETCH;
      S_OUT:   if (xfer) state_d = last_neu ? S_FIN : S_FETCH;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal driven here gets a hold/default value first so no latch is inferred.
  always_comb begin
    ngrp_d    = ngrp_q;
    nneu_d    = nneu_q;
    grp_idx_d = grp_idx_q;
    neu_idx_d = neu_idx_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    valid_d   = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ngrp_d    = (num_groups == '0) ? GRP_W'(1) : num_groups;
          nneu_d    = num_neurons;
          grp_idx_d = '0;
          neu_idx_d = '0;
          acc_d     = '0;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        if (last_grp) begin
          sum_d   = sum_load;
          valid_d = 1'b1;
        end else begin
          grp_idx_d = grp_idx_q + GRP_W'(1);
        end
      end
      S_OUT: begin
        if (xfer) begin
          valid_d   = 1'b0;
          acc_d     = '0;
          grp_idx_d = '0;
          if (!last_neu) neu_idx_d = neu_idx_q + NEU_W'(1);
        end
      end
      S_FIN:   neu_idx_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ngrp_q    <= '0;
      nneu_q    <= '0;
      grp_idx_q <= '0;
      neu_idx_q <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      ngrp_q    <= ngrp_d;
      nneu_q    <= nneu_d;
      grp_idx_q <= grp_idx_d;
      neu_idx_q <= neu_idx_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
    end
  end

  // Bias enters the tree only while the last group of a neuron is being accumulated.
  always_comb begin
    grp_rd   = (state_q == S_FETCH);
    bias_out = ((state_q == S_ACC) && last_grp) ? bias_in : '0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
  end

  assign grp_addr   = {neu_idx_q, grp_idx_q};
  assign neuron_idx = neu_idx_q;
  assign sum_out    = sum_q;
  assign sum_valid  = valid_q;

endmodule

// File: tb/tb_neuron_sum_sequencer.sv
// Randomized bench for neuron_sum_sequencer: an integer-arithmetic model supplies
// tree results and expected neuron sums; directed cases cover the documented corners.
module tb_neuron_sum_sequencer;

  localparam int GRP_W  = 4;
  localparam int NEU_W  = 6;
  localparam int ADDR_W = GRP_W + NEU_W;
  localparam int MAXM   = 1048575;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [GRP_W-1:0]  num_groups = '0;
  logic [NEU_W-1:0]  num_neurons = '0;
  logic [ADDR_W-1:0] grp_addr;
  logic              grp_rd;
  logic [14:0]       bias_in;
  logic [14:0]       bias_out;
  logic [NEU_W-1:0]  neuron_idx;
  logic [20:0]       tree_q;
  logic [20:0]       sum_out;
  logic              sum_valid;
  logic              sum_ready = 1'b0;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int gval [64][16];
  int bias [64];
  int pend_n = 0;
  int pend_g = 0;
  logic [20:0] last_sum = '0;

  always #5 clk = ~clk;

  neuron_sum_sequencer #(.GRP_W(GRP_W), .NEU_W(NEU_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_groups(num_groups), .num_neurons(num_neurons),
    .grp_addr(grp_addr), .grp_rd(grp_rd), .bias_in(bias_in), .bias_out(bias_out),
    .neuron_idx(neuron_idx), .tree_q(tree_q), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .busy(busy), .done(done)
  );

  function automatic int clampi(input int v);
    if (v > MAXM)  return MAXM;
    if (v < -MAXM) return -MAXM;
    return v;
  endfunction

  function automatic logic [20:0] to_sm21(input int v);
    return (v < 0) ? {1'b1, 20'(-v)} : {1'b0, 20'(v)};
  endfunction

  function automatic logic [14:0] to_sm15(input int v);
    return (v < 0) ? {1'b1, 14'(-v)} : {1'b0, 14'(v)};
  endfunction

  function automatic int sm15_to_int(input logic [14:0] s);
    return s[14] ? -int'(s[13:0]) : int'(s[13:0]);
  endfunction

  // Product memories + adder tree: one-cycle read latency, bias folded in by the tree.
  always @(posedge clk) begin
    if (grp_rd) begin
      pend_n <= int'(grp_addr[ADDR_W-1:GRP_W]);
      pend_g <= int'(grp_addr[GRP_W-1:0]);
    end
  end

  always_comb bias_in = to_sm15(bias[neuron_idx]);
  always_comb tree_q  = to_sm21(clampi(gval[pend_n][pend_g] + sm15_to_int(bias_out)));

  task automatic run_layer(input int ng, input int nn, input int hold, input int stall_pct,
                           input bit rand_start);
    logic [20:0] exp_sum [64];
    logic [20:0] held;
    int ng_eff, acc, t, neu, grp, first_fetch, hold_left;
    bit prev_rd, seen_valid, xfer_pending, done_expected, finished;
    ng_eff = (ng == 0) ? 1 : ng;
    for (int n = 0; n < nn; n++) begin
      acc = 0;
      for (int g = 0; g < ng_eff; g++) begin
        t   = clampi(gval[n][g] + ((g == ng_eff - 1) ? bias[n] : 0));
        acc = clampi(acc + t);
      end
`ifdef NEURON_SUM_RELU_EN
      if (acc < 0) acc = 0;
`endif
      exp_sum[n] = to_sm21(acc);
    end
    @(negedge clk);
    start = 1'b1; num_groups = GRP_W'(ng); num_neurons = NEU_W'(nn);
    @(negedge clk);
    start = 1'b0;
    neu = 0; grp = 0; first_fetch = 0; hold_left = hold; held = '0;
    prev_rd = 0; seen_valid = 0; xfer_pending = 0; done_expected = 0; finished = 0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (xfer_pending) begin
        checks++;
        if (sum_valid !== 1'b0) begin
          errors++; $display("FAIL valid_drop: sum_valid=%b expected 0", sum_valid);
        end
        checks++;
        if (done_expected) begin
          if (done !== 1'b1 || grp_rd !== 1'b0) begin
            errors++; $display("FAIL done_pulse: done=%b grp_rd=%b expected 1/0", done, grp_rd);
          end
          finished = 1;
        end else if (grp_rd !== 1'b1) begin
          errors++; $display("FAIL next_fetch: grp_rd=%b expected 1 after transfer", grp_rd);
        end
        xfer_pending = 0;
      end else if (done !== 1'b0) begin
        checks++; errors++;
        $display("FAIL early_done: done=%b expected 0 (neuron %0d)", done, neu);
        finished = 1;
      end
      if (!finished) begin
        if (grp_rd === 1'b1) begin
          checks++;
          if (grp_addr !== {NEU_W'(neu), GRP_W'(grp)}) begin
            errors++; $display("FAIL grp_addr: got %h expected %h", grp_addr, {NEU_W'(neu), GRP_W'(grp)});
          end
          if (grp == 0) first_fetch = cyc;
        end
        if (prev_rd) begin
          checks++;
          if (bias_out !== ((grp == ng_eff - 1) ? to_sm15(bias[neu]) : 15'd0)) begin
            errors++; $display("FAIL bias_out: got %h expected %h (grp %0d)", bias_out,
                               (grp == ng_eff - 1) ? to_sm15(bias[neu]) : 15'd0, grp);
          end
          grp = (grp == ng_eff - 1) ? 0 : grp + 1;
        end
        if (sum_valid === 1'b1) begin
          checks++;
          if (!seen_valid) begin
            seen_valid = 1; held = sum_out; last_sum = sum_out;
            if (cyc - first_fetch != 2 * ng_eff) begin
              errors++; $display("FAIL latency: got %0d expected %0d", cyc - first_fetch, 2 * ng_eff);
            end
            checks++;
            if (sum_out !== exp_sum[neu]) begin
              errors++; $display("FAIL sum_out: got %h expected %h (neuron %0d)", sum_out, exp_sum[neu], neu);
            end
          end else if (sum_out !== held) begin
            errors++; $display("FAIL sum_stable: got %h expected %h", sum_out, held);
          end
          checks++;
          if (grp_rd !== 1'b0) begin
            errors++; $display("FAIL fetch_while_valid: grp_rd=%b expected 0", grp_rd);
          end
        end
        prev_rd = (grp_rd === 1'b1);
        if (sum_valid === 1'b1 && hold_left > 0) begin
          sum_ready = 1'b0; hold_left--;
        end else begin
          sum_ready = ($urandom_range(0, 99) >= stall_pct);
        end
        if (sum_valid === 1'b1 && sum_ready) begin
          xfer_pending = 1; seen_valid = 0;
          if (neu == nn - 1) done_expected = 1;
          else neu++;
        end
        if (rand_start) begin
          start       = ($urandom_range(0, 3) == 0);
          num_groups  = GRP_W'($urandom);
          num_neurons = NEU_W'($urandom);
        end
      end else begin
        start = 1'b0; sum_ready = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!finished) begin
      errors++; $display("FAIL timeout: layer ng=%0d nn=%0d did not complete", ng, nn);
    end else if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_return: busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic randomize_layer(input int nn);
    for (int n = 0; n < nn; n++) begin
      bias[n] = int'($urandom_range(0, 16383)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      for (int g = 0; g < 16; g++) begin
        gval[n][g] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAXM))
                                                  : int'($urandom_range(0, 5000)))
                     * (($urandom_range(0, 1) == 1) ? -1 : 1);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, grp_rd, sum_valid, sum_out, bias_out, neuron_idx, grp_addr} !== '0) begin
      errors++; $display("FAIL reset_state: outputs=%h expected 0",
                         {busy, done, grp_rd, sum_valid, sum_out, bias_out, neuron_idx, grp_addr});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, grp_rd, sum_valid} !== 4'b0) begin
      errors++; $display("FAIL post_reset_idle: busy/done/rd/valid=%b expected 0000",
                         {busy, done, grp_rd, sum_valid});
    end
  endtask

  task automatic test_single();
    gval[0][0] = 100; bias[0] = 5;
    run_layer(1, 1, 0, 0, 0);
    checks++;
    if (last_sum !== 21'h000069) begin
      errors++; $display("FAIL single_sum: got %h expected 000069", last_sum);
    end
  endtask

  task automatic test_mixed_signs();
    gval[0][0] = 50; gval[0][1] = -80; gval[0][2] = 10; bias[0] = 0;
    run_layer(3, 1, 0, 30, 0);
    checks++;
`ifdef NEURON_SUM_RELU_EN
    if (last_sum !== 21'h000000) begin
      errors++; $display("FAIL mixed_sum: got %h expected 000000", last_sum);
    end
`else
    if (last_sum !== 21'h100014) begin
      errors++; $display("FAIL mixed_sum: got %h expected 100014", last_sum);
    end
`endif
  endtask

  task automatic test_cancel();
    gval[0][0] = 30; gval[0][1] = -30; bias[0] = 0;
    run_layer(2, 1, 0, 0, 0);
    checks++;
    if (last_sum !== 21'h000000) begin
      errors++; $display("FAIL cancel_sum: got %h expected 000000", last_sum);
    end
  endtask

  task automatic test_saturate();
    gval[0][0] = 'hFFFF0; gval[0][1] = 'hFFFF0; bias[0] = 0;
    run_layer(2, 1, 0, 0, 0);
    checks++;
    if (last_sum !== 21'h0FFFFF) begin
      errors++; $display("FAIL saturate_sum: got %h expected 0FFFFF", last_sum);
    end
  endtask

  task automatic test_backpressure();
    randomize_layer(2);
    run_layer(2, 2, 5, 0, 0);
  endtask

  task automatic test_zero_groups();
    randomize_layer(3);
    run_layer(0, 3, 0, 20, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nn;
      nn = int'($urandom_range(1, 5));
      randomize_layer(nn);
      run_layer(int'($urandom_range(0, 15)), nn, int'($urandom_range(0, 3)), 40, 1);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int bad;
    randomize_layer(1);
    @(negedge clk);
    start = 1'b1; num_groups = GRP_W'(3); num_neurons = NEU_W'(1);
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen < 2; c++) begin
      if (grp_rd === 1'b1) seen++;
      if (seen < 2) @(negedge clk);
    end
    checks++;
    if (seen < 2) begin
      errors++; $display("FAIL reset_mid_fetch: saw %0d fetches expected 2", seen);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, grp_rd, sum_valid, sum_out, bias_out, neuron_idx, grp_addr} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs: outputs=%h expected 0",
                         {busy, done, grp_rd, sum_valid, sum_out, bias_out, neuron_idx, grp_addr});
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || sum_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_quiet: %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_zero_neurons();
    @(negedge clk);
    start = 1'b1; num_groups = GRP_W'(5); num_neurons = '0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy, grp_rd} !== 3'b110) begin
      errors++; $display("FAIL zero_neurons_done: done/busy/rd=%b expected 110", {done, busy, grp_rd});
    end
    @(negedge clk);
    checks++;
    if ({done, busy, grp_rd} !== 3'b000) begin
      errors++; $display("FAIL zero_neurons_idle: done/busy/rd=%b expected 000", {done, busy, grp_rd});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_mixed_signs();
    test_cancel();
    test_saturate();
    test_backpressure();
    test_zero_groups();
    test_random();
    test_reset_mid();
    test_zero_neurons();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_sum_sequencer.md
Name: neuron_sum_sequencer

Overview:
Sequences the 8-input sign-magnitude adder tree over neurons with more than 8 inputs. It walks the input groups of each neuron and fetches 8 products per group. It accumulates the tree's 21-bit results into a sign-magnitude accumulator and injects the neuron bias only on the last group. Each finished neuron sum is handed to the activation stage over a valid/ready handshake. It sits between the weight/input memories plus multipliers and the activation/output buffer of one MLP layer.

Parameters:
GRP_W, 4, width of group count; 1..2^GRP_W-1 groups of 8 inputs per neuron
NEU_W, 6, width of neuron index/count
ADDR_W, GRP_W+NEU_W, width of product-memory group address

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; accepted only in IDLE
num_groups  in  GRP_W  groups per neuron, sampled at start; 0 treated as 1
num_neurons  in  NEU_W  neurons in layer, sampled at start; 0 -> immediate done
grp_addr  out  ADDR_W  {neuron_idx, group_idx} to product memories
grp_rd  out  1  read strobe; data valid at tree input next cycle (fixed 1-cycle latency)
bias_in  in  15  sign-mag bias of current neuron (addressed by neuron_idx)
bias_out  out  15  to tree bias port: bias_in on last group, else 15'd0
neuron_idx  out  NEU_W  current neuron
tree_q  in  21  sign-mag tree sum: bit20 sign, 19:0 magnitude
sum_out  out  21  finished neuron sum, sign-mag
sum_valid  out  1  sum_out valid
sum_ready  in  1  downstream accepts
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse after last neuron accepted

Behaviour:
- Reset (async): state IDLE; all counters, accumulator, sum_out = 0; grp_rd, sum_valid, done, busy = 0; bias_out = 0.
- States: IDLE, FETCH, ACC, OUT, FIN.
- IDLE: on start, latch num_groups/num_neurons and clear counters and accumulator. If num_neurons = 0, go FIN; else go FETCH. start in any other state is ignored.
- FETCH, one cycle: grp_rd = 1, grp_addr = {neuron_idx, group_idx}. Next state ACC.
- ACC, one cycle: bias_out = bias_in if group_idx = last, else 0.
  - Accumulate acc <= acc (+) tree_q.
  - If not last group: group_idx++, go FETCH.
  - If last group: load the result into sum_out, sum_valid = 1, go OUT.
  - Each group costs 2 cycles; neuron latency is 2*num_groups cycles from the first FETCH to sum_valid.
- Sign-magnitude add (+):
  - Equal signs: add magnitudes, keep sign; saturate magnitude at 20'hFFFFF.
  - Different signs: larger magnitude minus smaller, sign of larger.
  - Zero magnitude always has sign 0 (no negative zero).
- OUT: hold sum_out/sum_valid stable until sum_ready = 1; transfer occurs in a cycle where valid & ready.
  - On transfer: clear acc and group_idx.
  - If neuron_idx = num_neurons-1, go FIN; else neuron_idx++ and go FETCH.
  - sum_valid drops on the cycle after transfer unless a new sum is loaded.
- FIN: done = 1 for one cycle; go IDLE. neuron_idx resets to 0.
- busy = 1 in FETCH, ACC, OUT, FIN.
- Reset mid-operation: immediate return to reset values; a pending sum is dropped, no done.
- sum_ready high while not valid has no effect.

Optional Feature:
NEURON_SUM_RELU_EN
- Defined: the value loaded into sum_out is ReLU-applied; a negative result (sign = 1) becomes 21'd0. The accumulator itself is unaffected.
- Undefined: sum_out is the raw signed sum.

Test Plan:
- Reset then start, num_groups=1, num_neurons=1, tree_q=21'h000064 (+100), bias_in=15'h0005 -> bias_out=5 in ACC; sum_valid 2 cycles after FETCH. sum_out is whatever tree_q presents, since bias enters through the tree: the bench model supplies +105 and sum_out must equal 21'h000069. done pulses one cycle after the ready handshake.
- num_groups=3, tree_q +50, -80, +10 (bias 0) -> sum_out sign 1, magnitude 20 (21'h100014). bias_out=0 on groups 0 and 1.
- Cancellation: tree_q +30 then -30 -> sum_out=21'h000000 (positive zero).
- Saturation: tree_q 21'h0FFFF0 twice -> sum_out=21'h0FFFFF.
- Backpressure: num_neurons=2, sum_ready held 0 for 5 cycles -> sum_out stable, no FETCH issued. Neuron 1 fetch starts after the transfer; done only after the second transfer. With NEURON_SUM_RELU_EN, the -20 case yields 0.
- Async rst asserted in ACC of group 1 -> outputs zero immediately. Later start with num_neurons=0 -> done one cycle after leaving IDLE, no grp_rd.
